// File: rtl/os_pkg.sv
// Shared defaults and FSM state encodings for the overlap-save ping-pong output buffer.
package os_pkg;

  localparam int unsigned NFFT_DEFAULT = 32;
  localparam int unsigned W_DEFAULT    = 16;
  localparam int unsigned NBLK_DEFAULT = NFFT_DEFAULT / 2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DROP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_STREAM
  } rd_state_t;

endpackage

// File: rtl/os_pp_ram.sv
// Two-bank sample store: one write port, one read port with registered read data.
module os_pp_ram #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Read register only advances on i_re so the presented word holds during stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= mem[i_raddr];
    end
  end

endmodule

// File: rtl/os_pingpong_buffer.sv
// Ping-pong buffer between the discard-half stage and a valid/ready consumer;
// whole blocks are written into one bank while the other bank streams out.
module os_pingpong_buffer
  import os_pkg::*;
#(
  parameter int unsigned NFFT = NFFT_DEFAULT,
  parameter int unsigned W    = W_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic signed [W-1:0] i_y_re,
  input  logic signed [W-1:0] i_y_im,
  input  logic                i_first,
  input  logic                i_last,
  input  logic                i_ready,
  output logic                o_valid,
  output logic signed [W-1:0] o_y_re,
  output logic signed [W-1:0] o_y_im,
  output logic                o_last,
  output logic                o_overflow,
  output logic                o_frame_err
);

  localparam int unsigned    NBLK     = NFFT / 2;
  localparam int unsigned    IW       = $clog2(NBLK);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NBLK - 1);

  wr_state_t       wr_state;
  rd_state_t       rd_state;
  logic [1:0]      full;
  logic            wr_bank;
  logic            rd_bank;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;

  logic            ram_we;
  logic [IW-1:0]   ram_widx;
  logic            ram_re;
  logic [IW-1:0]   ram_ridx;
  logic [2*W-1:0]  ram_rdata;
  logic            wr_done;
  logic            xfer;
  logic            rd_release;

  os_pp_ram #(
    .AW(IW + 1),
    .DW(2 * W)
  ) u_ram (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (ram_we),
    .i_waddr({wr_bank, ram_widx}),
    .i_wdata({i_y_re, i_y_im}),
    .i_re   (ram_re),
    .i_raddr({rd_bank, ram_ridx}),
    .o_rdata(ram_rdata)
  );

  assign o_y_re = ram_rdata[2*W-1:W];
  assign o_y_im = ram_rdata[W-1:0];

  always_comb begin
    ram_we   = 1'b0;
    ram_widx = wr_idx;
    wr_done  = 1'b0;
    if (i_valid) begin
      unique case (wr_state)
        W_IDLE: begin
          if (i_first && !full[wr_bank]) begin
            ram_we   = 1'b1;
            ram_widx = '0;
          end
        end
        W_FILL: begin
          ram_we   = 1'b1;
          ram_widx = i_first ? '0 : wr_idx;
          wr_done  = !i_first && i_last && (wr_idx == LAST_IDX);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_state    <= W_IDLE;
      wr_bank     <= 1'b0;
      wr_idx      <= '0;
      o_overflow  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_overflow  <= 1'b0;
      o_frame_err <= 1'b0;
      if (i_valid) begin
        unique case (wr_state)
          W_IDLE: begin
            if (!i_first) begin
              o_frame_err <= 1'b1;
            end else if (full[wr_bank]) begin
              o_overflow <= 1'b1;
              if (!i_last) wr_state <= W_DROP;
            end else if (i_last) begin
              o_frame_err <= 1'b1;
            end else begin
              wr_idx   <= IW'(1);
              wr_state <= W_FILL;
            end
          end
          W_FILL: begin
            if (i_first) begin
              o_frame_err <= 1'b1;
              wr_idx      <= IW'(1);
            end else if (i_last) begin
              wr_idx   <= '0;
              wr_state <= W_IDLE;
              if (wr_idx == LAST_IDX) begin
                wr_bank <= ~wr_bank;
              end else begin
                o_frame_err <= 1'b1;
              end
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
          W_DROP: begin
            if (i_last) wr_state <= W_IDLE;
          end
          default: wr_state <= W_IDLE;
        endcase
      end
    end
  end

  assign xfer       = o_valid && i_ready;
  assign rd_release = xfer && o_last;

  // Next word is fetched on the accepting edge so the stream runs one beat per cycle.
  always_comb begin
    ram_re   = 1'b0;
    ram_ridx = rd_idx;
    unique case (rd_state)
      R_IDLE: begin
        if (full[rd_bank]) begin
          ram_re   = 1'b1;
          ram_ridx = '0;
        end
      end
      R_FETCH, R_STREAM: begin
        ram_re = xfer && !o_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_state <= R_IDLE;
      rd_bank  <= 1'b0;
      rd_idx   <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          if (full[rd_bank]) begin
            rd_idx   <= IW'(1);
            o_valid  <= 1'b1;
            o_last   <= 1'b0;
            rd_state <= R_FETCH;
          end
        end
        R_FETCH, R_STREAM: begin
          if (xfer) begin
            if (o_last) begin
              o_valid  <= 1'b0;
              o_last   <= 1'b0;
              rd_idx   <= '0;
              rd_bank  <= ~rd_bank;
              rd_state <= R_IDLE;
            end else begin
              rd_idx   <= rd_idx + IW'(1);
              o_last   <= (rd_idx == LAST_IDX);
              rd_state <= R_STREAM;
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // A bank is only ever completed while empty, so set and clear never target the same bank.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full <= '0;
    end else begin
      if (rd_release) full[rd_bank] <= 1'b0;
      if (wr_done)    full[wr_bank] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_os_pingpong_buffer.sv
// Self-checking bench for os_pingpong_buffer: vector table for idle-side errors,
// scoreboard queue for streamed data, and hand sequences for the multi-cycle corners.
module tb_os_pingpong_buffer;

  localparam int unsigned NFFT = 32;
  localparam int unsigned W    = 16;
  localparam int unsigned NBLK = NFFT / 2;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic                i_valid;
  logic signed [W-1:0] i_y_re;
  logic signed [W-1:0] i_y_im;
  logic                i_first;
  logic                i_last;
  logic                i_ready;
  logic                o_valid;
  logic signed [W-1:0] o_y_re;
  logic signed [W-1:0] o_y_im;
  logic                o_last;
  logic                o_overflow;
  logic                o_frame_err;

  os_pingpong_buffer #(
    .NFFT(NFFT),
    .W   (W)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_y_re     (i_y_re),
    .i_y_im     (i_y_im),
    .i_first    (i_first),
    .i_last     (i_last),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_y_re     (o_y_re),
    .o_y_im     (o_y_im),
    .o_last     (o_last),
    .o_overflow (o_overflow),
    .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
    logic                last;
  } exp_t;

  typedef struct {
    logic v;
    logic f;
    logic l;
    int   exp_ferr;
    int   exp_ovf;
  } vec_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_ovf = 0;
  int   n_ferr = 0;
  bit   rand_ready = 1'b0;
  bit   stall_pend = 1'b0;
  exp_t held;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (i_rst) begin
      stall_pend = 1'b0;
      return;
    end
    if (o_overflow) n_ovf++;
    if (o_frame_err) n_ferr++;
    if (o_overflow && o_frame_err) check("err_coincident", 1, 0);
    if (stall_pend) begin
      check("stall_valid", int'(o_valid), 1);
      check("stall_re", int'(o_y_re), int'(held.re));
      check("stall_im", int'(o_y_im), int'(held.im));
      check("stall_last", int'(o_last), int'(held.last));
    end
    stall_pend = o_valid && !i_ready;
    held.re = o_y_re;
    held.im = o_y_im;
    held.last = o_last;
    if (o_valid && i_ready) begin
      if (q.size() == 0) begin
        check("unexpected_beat", int'(o_y_re), -99999);
      end else begin
        e = q.pop_front();
        check("beat_re", int'(o_y_re), int'(e.re));
        check("beat_im", int'(o_y_im), int'(e.im));
        check("beat_last", int'(o_last), int'(e.last));
      end
    end
  endtask

  // One clock: sample outputs at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    #1;
    if (rand_ready) i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_block(input int len, input bit push, input bit with_last,
                            input bit rnd, input int off);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      if (rnd) begin
        e.re = W'($urandom);
        e.im = W'($urandom);
      end else begin
        e.re = W'(off + k);
        e.im = W'(-(off + k));
      end
      e.last  = (k == int'(NBLK) - 1);
      i_valid = 1'b1;
      i_first = (k == 0);
      i_last  = with_last && (k == len - 1);
      i_y_re  = e.re;
      i_y_im  = e.im;
      if (push) q.push_back(e);
      tick();
    end
    i_valid = 1'b0;
    i_first = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, q.size(), 0);
    repeat (4) tick();
  endtask

  vec_t vecs[6];
  int   ovf0;
  int   ferr0;
  int   gate;

  initial begin
    vecs[0] = '{v: 1'b1, f: 1'b0, l: 1'b0, exp_ferr: 1, exp_ovf: 0};
    vecs[1] = '{v: 1'b0, f: 1'b0, l: 1'b0, exp_ferr: 0, exp_ovf: 0};
    vecs[2] = '{v: 1'b1, f: 1'b0, l: 1'b1, exp_ferr: 1, exp_ovf: 0};
    vecs[3] = '{v: 1'b0, f: 1'b1, l: 1'b1, exp_ferr: 0, exp_ovf: 0};
    vecs[4] = '{v: 1'b1, f: 1'b1, l: 1'b1, exp_ferr: 1, exp_ovf: 0};
    vecs[5] = '{v: 1'b1, f: 1'b0, l: 1'b0, exp_ferr: 1, exp_ovf: 0};

    i_rst = 1'b1; i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
    i_y_re = '0; i_y_im = '0; i_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", int'(o_valid), 0);
    check("rst_last", int'(o_last), 0);
    check("rst_ovf", int'(o_overflow), 0);
    check("rst_ferr", int'(o_frame_err), 0);
    check("rst_re", int'(o_y_re), 0);
    check("rst_im", int'(o_y_im), 0);
    i_rst = 1'b0;
    tick();

    // Idle-side single-sample vectors against empty banks.
    foreach (vecs[i]) begin
      i_valid = vecs[i].v; i_first = vecs[i].f; i_last = vecs[i].l;
      i_y_re = W'(i); i_y_im = W'(i);
      tick();
      check("vec_ferr", int'(o_frame_err), vecs[i].exp_ferr);
      check("vec_ovf", int'(o_overflow), vecs[i].exp_ovf);
      check("vec_valid", int'(o_valid), 0);
      i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
    end
    tick();

    // Single block, ready high: latency and ordering.
    i_ready = 1'b1;
    send_block(NBLK, 1'b1, 1'b1, 1'b0, 0);
    check("lat_t1_valid", int'(o_valid), 0);
    tick();
    check("lat_t2_valid", int'(o_valid), 1);
    check("lat_t2_re", int'(o_y_re), 0);
    check("lat_t2_im", int'(o_y_im), 0);
    drain("blk1_drain", 100);

    // Three back-to-back blocks while stalled: third overflows.
    ovf0 = n_ovf; ferr0 = n_ferr;
    i_ready = 1'b0;
    send_block(NBLK, 1'b1, 1'b1, 1'b0, 100);
    send_block(NBLK, 1'b1, 1'b1, 1'b0, 200);
    send_block(NBLK, 1'b0, 1'b1, 1'b0, 300);
    tick();
    check("ovf3_count", n_ovf - ovf0, 1);
    check("ovf3_ferr", n_ferr - ferr0, 0);
    i_ready = 1'b1;
    drain("ovf3_drain", 200);

    // Short block, then a restart mid-fill, then a good block.
    ovf0 = n_ovf; ferr0 = n_ferr;
    send_block(10, 1'b0, 1'b1, 1'b0, 400);
    tick();
    check("short_no_out", int'(o_valid), 0);
    send_block(5, 1'b0, 1'b0, 1'b0, 450);
    send_block(NBLK, 1'b1, 1'b1, 1'b0, 500);
    tick();
    check("ferr_count", n_ferr - ferr0, 2);
    drain("ferr_drain", 100);
    check("ferr_ovf", n_ovf - ovf0, 0);

    // Reset at index 7 of a block while the previous block streams.
    send_block(NBLK, 1'b1, 1'b1, 1'b0, 600);
    for (int k = 0; k < 7; k++) begin
      i_valid = 1'b1; i_first = (k == 0); i_last = 1'b0;
      i_y_re = W'(700 + k); i_y_im = W'(-(700 + k));
      tick();
    end
    check("pre_rst_streaming", int'(o_valid), 1);
    i_valid = 1'b0; i_first = 1'b0;
    i_rst = 1'b1;
    q.delete();
    tick();
    check("rst_mid_valid", int'(o_valid), 0);
    check("rst_mid_re", int'(o_y_re), 0);
    i_rst = 1'b0;
    tick();
    repeat (3) tick();
    check("rst_mid_idle", int'(o_valid), 0);
    send_block(NBLK, 1'b1, 1'b1, 1'b0, 800);
    drain("rst_drain", 100);

    // Release of a bank in the same cycle as i_first into it.
    ovf0 = n_ovf;
    i_ready = 1'b0;
    send_block(NBLK, 1'b1, 1'b1, 1'b0, 1000);
    send_block(NBLK, 1'b1, 1'b1, 1'b0, 1100);
    tick();
    tick();
    i_ready = 1'b1;
    repeat (NBLK - 1) tick();
    send_block(NBLK, 1'b0, 1'b1, 1'b0, 1200);
    tick();
    check("same_cycle_ovf", n_ovf - ovf0, 1);
    drain("same_cycle_drain", 100);

    // Random ready over 100 random blocks.
    ovf0 = n_ovf; ferr0 = n_ferr;
    rand_ready = 1'b1;
    for (int b = 0; b < 100; b++) begin
      gate = 0;
      while (q.size() > int'(NBLK) && gate < 400) begin
        tick();
        gate++;
      end
      if (q.size() > int'(NBLK)) check("rand_gate", q.size(), NBLK);
      send_block(NBLK, 1'b1, 1'b1, 1'b1, 0);
    end
    drain("rand_drain", 2000);
    rand_ready = 1'b0;
    i_ready = 1'b1;
    check("rand_ovf", n_ovf - ovf0, 0);
    check("rand_ferr", n_ferr - ferr0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/os_pingpong_buffer.md
OS_PINGPONG_BUFFER -- requirements
Module: os_pingpong_buffer

Interface
REQ-001 The block SHALL have parameter NFFT, default 32, meaning FFT length; good block length NBLK = NFFT/2.
REQ-002 The block SHALL have parameter W, default 16, meaning sample width per re/im component.
REQ-003 The block SHALL have port i_clk  input  1  clock, all logic on rising edge.
REQ-004 The block SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have ports i_valid  input  1, i_y_re and i_y_im  input  W signed, i_first  input  1, i_last  input  1: the burst of good samples from the discard-half stage, with no backpressure.
REQ-006 The block SHALL have port i_ready  input  1  downstream ready.
REQ-007 The block SHALL have ports o_valid  output  1, o_y_re and o_y_im  output  W signed, o_last  output  1: the output stream, with o_last on sample NBLK-1 of each block.
REQ-008 The block SHALL have ports o_overflow  output  1 and o_frame_err  output  1, each a one-cycle error pulse.

Function
REQ-009 The block SHALL store data in two banks of NBLK complex entries, each with a full flag.
REQ-010 Write FSM states SHALL be W_IDLE, W_FILL and W_DROP.
REQ-011 In W_IDLE, i_valid & i_first SHALL behave as follows: if full[wr_bank]=0, write index 0 and go to W_FILL; else pulse o_overflow and go to W_DROP (or stay in W_IDLE if i_last is also high).
REQ-012 In W_IDLE, i_valid without i_first SHALL discard the sample and pulse o_frame_err.
REQ-013 In W_FILL, each i_valid SHALL write at wr_idx and then increment wr_idx; i_valid low SHALL hold wr_idx.
REQ-014 In W_FILL, i_last with wr_idx==NBLK-1 SHALL set full[wr_bank], toggle wr_bank and return to W_IDLE.
REQ-015 In W_FILL, i_last with wr_idx!=NBLK-1 SHALL pulse o_frame_err, leave the bank not full and return to W_IDLE.
REQ-016 In W_FILL, i_first SHALL pulse o_frame_err and restart the same bank at index 0 with this sample.
REQ-017 In W_DROP, samples SHALL be ignored until i_last, then the FSM returns to W_IDLE; NFFT-boundary data is never partially written.
REQ-018 Read FSM states SHALL be R_IDLE, R_FETCH and R_STREAM; it reads rd_bank when full[rd_bank]=1.
REQ-019 Output SHALL follow valid/ready rules: o_valid, o_y_*, o_last hold stable while o_valid & !i_ready; a transfer occurs on o_valid & i_ready.
REQ-020 Latency: with the read side idle and i_last accepted in cycle T, o_valid SHALL be high in cycle T+2 carrying entry 0.
REQ-021 Throughput with i_ready held high SHALL be one sample per cycle within a block, with at most one bubble cycle between consecutive blocks.
REQ-022 The transfer of o_last SHALL clear full[rd_bank] and toggle rd_bank; a bank freed in cycle T is writable from cycle T+1.
REQ-023 When a write completion and a read release hit different banks in the same cycle, both SHALL take effect.
REQ-024 Data SHALL pass bit-exact; no arithmetic is applied.
REQ-025 o_overflow and o_frame_err SHALL never pulse in the same cycle for the same sample; overflow takes priority.

Reset
REQ-026 i_rst SHALL clear both full flags, wr_bank, rd_bank, wr_idx and rd_idx to 0, and set both FSMs to IDLE.
REQ-027 i_rst SHALL drive o_valid, o_last, o_overflow and o_frame_err to 0, and o_y_re and o_y_im to 0, from the cycle after reset is asserted.
REQ-028 Reset mid-block SHALL discard partial and stored contents; no stale sample may appear after reset.

Structure
REQ-029 Package os_pkg SHALL hold the NFFT/W defaults, NBLK and the write and read FSM state encodings.
REQ-030 Storage SHALL be sub-module os_pp_ram: 2*NBLK x 2W words, one write port, one read port with a 1-cycle registered read; address = {bank, idx}.

Verification
REQ-031 One block with samples re=k, im=-k for k=0..15 and i_ready=1 -> o_valid from T+2, 16 beats in order, o_last on re=15.
REQ-032 Three back-to-back blocks with i_ready=0 -> blocks 1-2 are stored; block 3 pulses o_overflow and is dropped; after release, outputs are blocks 1 then 2 only.
REQ-033 Random i_ready (50%) over 100 blocks -> output equals input sequence with no loss and o_y_* stable during stalls.
REQ-034 i_last at index 9 -> o_frame_err pulse and no output for that block; the next correct block outputs normally.
REQ-035 i_rst asserted at index 7 of a block while another block is streaming -> o_valid=0 the next cycle; the next full block outputs correctly from entry 0.
REQ-036 Last-sample read release in the same cycle as i_first to that bank -> o_overflow pulse, because the release is usable only from the next cycle.
